rob_commit_ctrl: RTL and testbench
==================================

Name: rob_commit_ctrl

Overview:
- Sequences retirement after the reorder buffer's 4-wide commit.
- Accepts commit rows of four physical destination registers (prd) and queues them in a small row FIFO.
- Releases the prds to the free list one per cycle over a valid/ready handshake.
- Backpressures ROB commit when full; provides a drain-and-acknowledge sequence so exception/flush logic can wait until every committed prd is returned.

Parameters:
- WIDTH_REG, 7, physical register index width.
- DEPTH, 4, row FIFO entries; power of two, >= 2.

Ports:
- i_clk  input  1  clock, all state updates on rising edge.
- i_rst  input  1  synchronous active-high reset.
- i_com_en  input  1  commit row valid; ROB head row retires this cycle.
- i_com_prd4x  input  4*WIDTH_REG  commit row; slot k in bits [(k+1)*WIDTH_REG-1 : k*WIDTH_REG].
- o_com_stall  output  1  ROB must not assert i_com_en while high.
- o_free_prd  output  WIDTH_REG  prd being released.
- o_free_val  output  1  o_free_prd valid.
- i_free_rdy  input  1  free list accepts; transfer = o_free_val & i_free_rdy.
- i_flush  input  1  drain request, single-cycle pulse.
- o_flush_done  output  1  one-cycle pulse when the drain completes.
- o_count  output  $clog2(DEPTH)+1  occupied row entries.
- o_ovf  output  1  sticky error: commit arrived while stalled.

Behaviour:
- Reset (i_rst high at a clock edge):
  - FIFO emptied; head/tail pointers and count = 0.
  - All pending masks cleared.
  - o_free_val=0, o_free_prd=0, o_flush_done=0, o_ovf=0, state=IDLE.
  - Reset mid-operation discards queued prds without releasing them.
- Row entry: four prd fields plus a 4-bit pending mask. Bit k = (prd_k != 0); prd 0 (x0) is never freed.
- Push condition: i_com_en & ~o_com_stall & (mask != 0).
  - All-zero-mask rows are consumed and never enqueued.
  - Row is written at tail; tail advances modulo DEPTH, wrapping DEPTH-1 to 0.
- Release selection:
  - o_free_val = count != 0.
  - o_free_prd = lowest-index pending slot of the head row (combinational from registers); 0 when empty.
- On transfer:
  - The head row's selected pending bit is cleared.
  - If that was its last pending bit, the row pops and head advances modulo DEPTH.
  - A row with N valid prds takes N transfer cycles minimum.
  - Release order: row order, then slot 0..3.
- Simultaneous push and pop in one cycle: count unchanged, both pointers move.
- Write-through bypass: none. A row pushed into an empty FIFO is first visible the following cycle, so minimum commit-to-free latency is 1 cycle.
- o_com_stall = (count == DEPTH) | (state == FLUSH) | (state == DONE).
  - Registered-count based: a pop in the same cycle does not lift a full stall.
- i_com_en while o_com_stall: row ignored, o_ovf set (sticky until reset).
- o_count: occupied rows; range 0..DEPTH.
- FSM states IDLE, RUN, FLUSH, DONE:
  - IDLE: count==0. Push -> RUN. i_flush -> DONE.
  - RUN: count>0. Count reaching 0 with no push -> IDLE. i_flush -> FLUSH.
  - FLUSH: commit stalled, queue draining. Queue empties (last pop, count becomes 0) -> DONE.
  - DONE: o_flush_done=1 for exactly this cycle -> IDLE unconditionally.
  - i_flush is ignored while in FLUSH or DONE.
  - i_flush coincident with a push in IDLE/RUN: the push is accepted and drained before done.
- i_free_rdy low holds o_free_prd/o_free_val stable; no state change except pushes.

Test Plan:
- Reset, then a single row: i_com_en with prd4x = {0,12,0,5} (slot3..slot0) -> next cycle o_free_prd=5, then 12 (i_free_rdy=1), o_count 1->0, state back to IDLE.
- All-zero row {0,0,0,0} with i_com_en -> o_count stays 0, o_free_val stays 0, o_ovf=0.
- Fill: i_free_rdy=0, DEPTH=4, four full rows -> o_count=4, o_com_stall=1. A fifth i_com_en -> row dropped, o_ovf=1. Release i_free_rdy -> 16 prds out in push order, stall drops when o_count=3.
- Wrap-around: 7 rows pushed and drained interleaved with i_free_rdy toggling each cycle -> every nonzero prd is freed exactly once, in order, across the pointer wrap.
- Flush: 2 rows queued (5 prds), i_flush pulse -> o_com_stall=1 immediately. o_flush_done pulses one cycle after the 5th transfer. i_flush in IDLE -> o_flush_done the next cycle.
- Reset mid-drain: i_rst asserted with 3 rows queued -> next cycle o_count=0, o_free_val=0, state IDLE, o_ovf cleared.

Source files
------------

// File: rtl/rob_commit_ctrl.sv
// Retirement sequencer: queues 4-wide ROB commit rows and releases nonzero prds to the free list one per cycle.
// Latency: commit-to-free minimum 1 cycle (no bypass); stalls commit when the row FIFO is full or a drain is in progress.
module rob_commit_ctrl #(
    parameter int WIDTH_REG = 7,
    parameter int DEPTH     = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_com_en,
    input  logic [4*WIDTH_REG-1:0]     i_com_prd4x,
    output logic                       o_com_stall,
    output logic [WIDTH_REG-1:0]       o_free_prd,
    output logic                       o_free_val,
    input  logic                       i_free_rdy,
    input  logic                       i_flush,
    output logic                       o_flush_done,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t               r_state, w_state_nxt;
    logic [WIDTH_REG-1:0] r_prd [DEPTH][4];
    logic [3:0]           r_mask [DEPTH];
    logic [PW-1:0]        r_head, r_tail;
    logic [CW-1:0]        r_count, w_count_nxt;
    logic                 r_ovf;
    logic [3:0]           w_in_mask, w_head_mask;
    logic [1:0]           w_sel;
    logic                 w_push, w_xfer, w_pop, w_stall;

    // Slot k is pending only if its prd is nonzero; x0 is never returned.
    always_comb begin
        w_in_mask = 4'b0;
        for (int k = 0; k < 4; k++)
            w_in_mask[k] = (i_com_prd4x[k*WIDTH_REG +: WIDTH_REG] != '0);
    end

    assign w_head_mask = r_mask[r_head];

    // Descending scan so the lowest pending slot wins.
    always_comb begin
        w_sel = 2'd0;
        for (int k = 3; k >= 0; k--)
            if (w_head_mask[k]) w_sel = 2'(k);
    end

    assign w_stall    = (r_count == CW'(DEPTH)) | (r_state == FLUSH) | (r_state == DONE);
    assign o_free_val = (r_count != '0);
    assign w_xfer     = o_free_val & i_free_rdy;
    assign w_pop      = w_xfer & ((w_head_mask & ~(4'b0001 << w_sel)) == 4'b0);
    assign w_push     = i_com_en & ~w_stall & (w_in_mask != 4'b0);
    assign o_free_prd = o_free_val ? r_prd[r_head][w_sel] : '0;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push & ~w_pop)
            w_count_nxt = r_count + CW'(1);
        else if (~w_push & w_pop)
            w_count_nxt = r_count - CW'(1);
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_com_stall  = w_stall;
        o_flush_done = (r_state == DONE);
        case (r_state)
            IDLE: begin
                if (i_flush)
                    w_state_nxt = w_push ? FLUSH : DONE;
                else if (w_push)
                    w_state_nxt = RUN;
            end
            RUN: begin
                // A flush that coincides with the final pop has nothing left to drain.
                if (i_flush)
                    w_state_nxt = (w_count_nxt == '0) ? DONE : FLUSH;
                else if (w_count_nxt == '0)
                    w_state_nxt = IDLE;
            end
            FLUSH: begin
                if (w_count_nxt == '0)
                    w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            for (int d = 0; d < DEPTH; d++)
                r_mask[d] <= 4'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (i_com_en & w_stall)
                r_ovf <= 1'b1;
            if (w_xfer) begin
                r_mask[r_head][w_sel] <= 1'b0;
                if (w_pop)
                    r_head <= r_head + PW'(1);
            end
            // Push and transfer never target the same row: push needs not-full, transfer needs not-empty.
            if (w_push) begin
                r_mask[r_tail] <= w_in_mask;
                r_tail         <= r_tail + PW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            for (int k = 0; k < 4; k++)
                r_prd[r_tail][k] <= i_com_prd4x[k*WIDTH_REG +: WIDTH_REG];
        end
    end

    assign o_count = r_count;
    assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl with a queue-based reference model checked every cycle.
module tb_rob_commit_ctrl;

    localparam int W     = 7;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          com_en = 1'b0;
    logic [4*W-1:0] com_prd = '0;
    logic          free_rdy = 1'b0;
    logic          flush = 1'b0;
    logic          com_stall, free_val, flush_done, ovf;
    logic [W-1:0]  free_prd;
    logic [2:0]    count;

    int n_checks = 0;
    int n_errors = 0;

    rob_commit_ctrl #(.WIDTH_REG(W), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_com_en(com_en), .i_com_prd4x(com_prd),
        .o_com_stall(com_stall), .o_free_prd(free_prd), .o_free_val(free_val),
        .i_free_rdy(free_rdy), .i_flush(flush), .o_flush_done(flush_done),
        .o_count(count), .o_ovf(ovf)
    );

    always #5 clk = ~clk;

    // Reference model: a flat queue of pending prds plus per-row remaining counts.
    int q_prd[$];
    int q_len[$];
    int dut_freed[$];
    bit m_ovf = 0, m_fl = 0, m_done = 0, m_valid = 0;

    function automatic bit m_stall();
        return (q_len.size() == DEPTH) || m_fl || m_done;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (free_val && free_rdy && !rst) dut_freed.push_back(int'(free_prd));
        if (rst) begin
            q_prd.delete(); q_len.delete();
            m_ovf = 0; m_fl = 0; m_done = 0; m_valid = 1;
        end else begin
            automatic bit st = m_stall();
            automatic int n = 0;
            for (int k = 0; k < 4; k++) if (com_prd[k*W +: W] != 0) n++;
            if (com_en && st) m_ovf = 1;
            if (free_rdy && q_len.size() > 0) begin
                void'(q_prd.pop_front());
                q_len[0] = q_len[0] - 1;
                if (q_len[0] == 0) void'(q_len.pop_front());
            end
            if (com_en && !st && n > 0) begin
                for (int k = 0; k < 4; k++)
                    if (com_prd[k*W +: W] != 0) q_prd.push_back(int'(com_prd[k*W +: W]));
                q_len.push_back(n);
            end
            if (m_done) m_done = 0;
            else if (flush && !m_fl) m_fl = 1;
            if (m_fl && q_len.size() == 0) begin
                m_fl = 0;
                m_done = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("free_val", int'(free_val), int'(q_len.size() != 0));
            chk("free_prd", int'(free_prd), (q_len.size() != 0) ? q_prd[0] : 0);
            chk("count", int'(count), q_len.size());
            chk("com_stall", int'(com_stall), int'(m_stall()));
            chk("flush_done", int'(flush_done), int'(m_done));
            chk("ovf", int'(ovf), int'(m_ovf));
        end
    end

    function automatic logic [4*W-1:0] mkrow(input int a0, input int a1, input int a2, input int a3);
        return {W'(a3), W'(a2), W'(a1), W'(a0)};
    endfunction

    task automatic cyc(input bit en, input logic [4*W-1:0] p, input bit rdy, input bit fl, input bit r);
        com_en = en; com_prd = p; free_rdy = rdy; flush = fl; rst = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_q[$];
        int idx;
        int guard;
        bit en;

        cyc(0, '0, 0, 0, 1);
        cyc(0, '0, 0, 0, 1);
        chk("rst_count", int'(count), 0);
        chk("rst_val", int'(free_val), 0);
        chk("rst_ovf", int'(ovf), 0);

        // Single row {0,12,0,5}
        cyc(1, mkrow(5, 0, 12, 0), 1, 0, 0);
        chk("row1_prd0", int'(free_prd), 5);
        chk("row1_cnt0", int'(count), 1);
        cyc(0, '0, 1, 0, 0);
        chk("row1_prd1", int'(free_prd), 12);
        chk("row1_cnt1", int'(count), 1);
        cyc(0, '0, 1, 0, 0);
        chk("row1_cnt2", int'(count), 0);
        chk("row1_val2", int'(free_val), 0);
        chk("row1_nfreed", dut_freed.size(), 2);
        if (dut_freed.size() == 2) begin
            chk("row1_f0", dut_freed[0], 5);
            chk("row1_f1", dut_freed[1], 12);
        end

        // All-zero row is consumed silently
        cyc(1, '0, 1, 0, 0);
        chk("zero_cnt", int'(count), 0);
        chk("zero_val", int'(free_val), 0);
        chk("zero_ovf", int'(ovf), 0);

        // Fill to full, then overflow attempt
        dut_freed.delete();
        for (int i = 0; i < 4; i++)
            cyc(1, mkrow(i*4+1, i*4+2, i*4+3, i*4+4), 0, 0, 0);
        chk("fill_cnt", int'(count), 4);
        chk("fill_stall", int'(com_stall), 1);
        cyc(1, mkrow(100, 101, 102, 103), 0, 0, 0);
        chk("fill_ovf", int'(ovf), 1);
        chk("fill_cnt5", int'(count), 4);
        for (int c = 0; c < 18; c++) cyc(0, '0, 1, 0, 0);
        chk("fill_nfreed", dut_freed.size(), 16);
        for (int i = 0; i < 16 && i < dut_freed.size(); i++)
            chk("fill_order", dut_freed[i], i + 1);

        // Wrap-around with toggling ready
        dut_freed.delete();
        exp_q.delete();
        for (int j = 0; j < 7; j++)
            for (int k = 0; k < 4; k++)
                if ((j + k) % 3 != 0) exp_q.push_back(j*4 + k + 20);
        idx = 0;
        guard = 0;
        while ((idx < 7 || q_len.size() != 0) && guard < 200) begin
            en = (idx < 7) && !m_stall();
            cyc(en, mkrow(((idx+0)%3 != 0) ? idx*4+20 : 0, ((idx+1)%3 != 0) ? idx*4+21 : 0,
                          ((idx+2)%3 != 0) ? idx*4+22 : 0, ((idx+3)%3 != 0) ? idx*4+23 : 0),
                guard[0], 0, 0);
            if (en) idx++;
            guard++;
        end
        chk("wrap_timeout", int'(guard < 200), 1);
        chk("wrap_nfreed", dut_freed.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < dut_freed.size(); i++)
            chk("wrap_order", dut_freed[i], exp_q[i]);

        // Flush with 2 rows (5 prds) queued
        cyc(1, mkrow(40, 41, 0, 0), 0, 0, 0);
        cyc(1, mkrow(42, 0, 43, 44), 0, 0, 0);
        chk("fl_cnt", int'(count), 2);
        cyc(0, '0, 0, 1, 0);
        chk("fl_stall", int'(com_stall), 1);
        chk("fl_done0", int'(flush_done), 0);
        for (int c = 1; c <= 5; c++) begin
            cyc(0, '0, 1, 0, 0);
            chk("fl_done_n", int'(flush_done), int'(c == 5));
        end
        cyc(0, '0, 1, 0, 0);
        chk("fl_done_after", int'(flush_done), 0);
        chk("fl_stall_after", int'(com_stall), 0);
        cyc(0, '0, 1, 1, 0);
        chk("idle_fl_done", int'(flush_done), 1);
        cyc(0, '0, 1, 0, 0);
        chk("idle_fl_done1", int'(flush_done), 0);

        // Reset mid-drain
        for (int i = 0; i < 3; i++) cyc(1, mkrow(i+60, i+70, 0, 0), 0, 0, 0);
        chk("mr_cnt", int'(count), 3);
        chk("mr_ovf_pre", int'(ovf), 1);
        cyc(0, '0, 0, 0, 1);
        chk("mr_cnt0", int'(count), 0);
        chk("mr_val0", int'(free_val), 0);
        chk("mr_ovf0", int'(ovf), 0);
        chk("mr_stall0", int'(com_stall), 0);
        cyc(0, '0, 1, 0, 0);
        cyc(0, '0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
